// File: rtl/agu_reservation_queue_param.sv
// agu_reservation_queue_param
// Age-ordered collapsing reservation queue for address-generation (load/store)
// instructions. Entries capture pending operands from the CDB, one ready entry
// is selected and locked until the execution unit reports ex_done, and the
// effective address op1 + imm is presented combinationally.
//
// Parameters: DEPTH (entries, >= 2), DATA_W (operand/address width),
//             TAG_W (CDB/ROB tag width), IN_ORDER (1: oldest only, 0: oldest ready)
// Ports:
//   clk, rst (sync active-high), flush          - clock, reset, discard all entries
//   queue_en + queue_*_in                       - dispatch write port
//   queue_full, queue_count                     - occupancy status
//   cdb_valid, cdb_tag, cdb_data                - common data bus broadcast
//   ex_done                                     - execution unit consumed issued entry
//   issue_valid, ex_address, ex_data,
//   queue_rd_tag_out, queue_rd_tag_valid_out,
//   queue_funct3_out, queue_agu_ls_out          - issue port (all zero when idle)
module agu_reservation_queue_param #(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 6,
  parameter int IN_ORDER = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         queue_en,
  input  logic [DATA_W-1:0]            queue_op1_data_in,
  input  logic [DATA_W-1:0]            queue_op2_data_in,
  input  logic [TAG_W-1:0]             queue_op1_tag_in,
  input  logic [TAG_W-1:0]             queue_op2_tag_in,
  input  logic                         queue_op1_data_valid_in,
  input  logic                         queue_op2_data_valid_in,
  input  logic [TAG_W-1:0]             queue_rd_tag_in,
  input  logic                         queue_rd_tag_valid_in,
  input  logic [2:0]                   queue_funct3_in,
  input  logic                         queue_agu_ls_in,
  input  logic [DATA_W-1:0]            queue_agu_imm_in,
  output logic                         queue_full,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  input  logic                         ex_done,
  output logic                         issue_valid,
  output logic [DATA_W-1:0]            ex_address,
  output logic [DATA_W-1:0]            ex_data,
  output logic [TAG_W-1:0]             queue_rd_tag_out,
  output logic                         queue_rd_tag_valid_out,
  output logic [2:0]                   queue_funct3_out,
  output logic                         queue_agu_ls_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] op1_data;
    logic [TAG_W-1:0]  op1_tag;
    logic              op1_v;
    logic [DATA_W-1:0] op2_data;
    logic [TAG_W-1:0]  op2_tag;
    logic              op2_v;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_v;
    logic [2:0]        funct3;
    logic              ls;
    logic [DATA_W-1:0] imm;
  } entry_t;

  entry_t          ent_r [DEPTH];
  // One extra all-zero slot so the collapsing shift never indexes past the end.
  entry_t          woke_s [DEPTH+1];
  entry_t          ent_nxt_s [DEPTH];
  entry_t          new_s;
  entry_t          sel_ent_s;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_after_s;
  logic [CW-1:0]   count_nxt_s;
  logic            lock_r;
  logic [IW-1:0]   lock_idx_r;
  logic [DEPTH-1:0] ready_s;
  logic [IW-1:0]   sel_s;
  logic            issue_s;
  logic            remove_s;
  logic            dispatch_s;
  logic            full_s;
  logic            hit1_new_s;
  logic            hit2_new_s;

  assign full_s      = (count_r == CW'(DEPTH));
  assign queue_full  = full_s;
  assign queue_count = count_r;

  // Readiness: loads need only the base register, stores also need store data.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_s[i] = ent_r[i].valid && ent_r[i].op1_v && (!ent_r[i].ls || ent_r[i].op2_v);
    end
  end

  // Issue selection: a held lock wins; otherwise entry 0 (in-order) or the lowest ready entry.
  always_comb begin
    sel_s   = '0;
    issue_s = 1'b0;
    if (lock_r) begin
      sel_s   = lock_idx_r;
      issue_s = 1'b1;
    end else if (IN_ORDER != 0) begin
      sel_s   = '0;
      issue_s = ready_s[0];
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        sel_s   = (!issue_s && ready_s[i]) ? IW'(i) : sel_s;
        issue_s = issue_s || ready_s[i];
      end
    end
  end

  // CDB wakeup of resident entries and dispatch-cycle bypass for the incoming entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke_s[i] = ent_r[i];
      if (ent_r[i].valid && !ent_r[i].op1_v && cdb_valid && (ent_r[i].op1_tag == cdb_tag)) begin
        woke_s[i].op1_v    = 1'b1;
        woke_s[i].op1_data = cdb_data;
      end else begin
        woke_s[i].op1_v    = ent_r[i].op1_v;
      end
      if (ent_r[i].valid && !ent_r[i].op2_v && cdb_valid && (ent_r[i].op2_tag == cdb_tag)) begin
        woke_s[i].op2_v    = 1'b1;
        woke_s[i].op2_data = cdb_data;
      end else begin
        woke_s[i].op2_v    = ent_r[i].op2_v;
      end
    end
    woke_s[DEPTH] = '0;

    hit1_new_s      = !queue_op1_data_valid_in && cdb_valid && (queue_op1_tag_in == cdb_tag);
    hit2_new_s      = !queue_op2_data_valid_in && cdb_valid && (queue_op2_tag_in == cdb_tag);
    new_s.valid     = 1'b1;
    new_s.op1_data  = hit1_new_s ? cdb_data : queue_op1_data_in;
    new_s.op1_tag   = queue_op1_tag_in;
    new_s.op1_v     = queue_op1_data_valid_in || hit1_new_s;
    new_s.op2_data  = hit2_new_s ? cdb_data : queue_op2_data_in;
    new_s.op2_tag   = queue_op2_tag_in;
    new_s.op2_v     = queue_op2_data_valid_in || hit2_new_s;
    new_s.rd_tag    = queue_rd_tag_in;
    new_s.rd_v      = queue_rd_tag_valid_in;
    new_s.funct3    = queue_funct3_in;
    new_s.ls        = queue_agu_ls_in;
    new_s.imm       = queue_agu_imm_in;
  end

  // Next entry state: collapse above the removed slot, then append the dispatched entry.
  always_comb begin
    remove_s      = ex_done && issue_s;
    dispatch_s    = queue_en && !full_s;
    count_after_s = count_r - CW'(remove_s);
    for (int i = 0; i < DEPTH; i++) begin
      if (remove_s && (i >= int'(sel_s))) begin
        ent_nxt_s[i] = woke_s[i+1];
      end else begin
        ent_nxt_s[i] = woke_s[i];
      end
      if (dispatch_s && (count_after_s == CW'(i))) begin
        ent_nxt_s[i] = new_s;
      end else begin
        ent_nxt_s[i] = ent_nxt_s[i];
      end
    end
    count_nxt_s = count_after_s + CW'(dispatch_s);
  end

  // State registers: entries, occupancy and the issue lock (flush behaves like reset).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= '0;
      end
      count_r    <= '0;
      lock_r     <= 1'b0;
      lock_idx_r <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= ent_nxt_s[i];
      end
      count_r    <= count_nxt_s;
      lock_r     <= issue_s && !remove_s;
      lock_idx_r <= sel_s;
    end
  end

  assign sel_ent_s              = ent_r[sel_s];
  assign issue_valid            = issue_s;
  assign ex_address             = issue_s ? (sel_ent_s.op1_data + sel_ent_s.imm) : '0;
  assign ex_data                = issue_s ? sel_ent_s.op2_data : '0;
  assign queue_rd_tag_out       = issue_s ? sel_ent_s.rd_tag : '0;
  assign queue_rd_tag_valid_out = issue_s ? sel_ent_s.rd_v : 1'b0;
  assign queue_funct3_out       = issue_s ? sel_ent_s.funct3 : 3'b000;
  assign queue_agu_ls_out       = issue_s ? sel_ent_s.ls : 1'b0;

endmodule
